// File: rtl/wb_multi_initiator_pkg.sv
// Shared types and sizing helpers for the multi-channel Wishbone initiator.
// The optional bus-hang timeout is enabled by defining WB_MULTI_INITIATOR_TIMEOUT_EN.
package wb_multi_initiator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RSP  = 2'd2
   } state_e;

   localparam int TMO_CNT_W = 16;

   // A single channel still needs a one-bit index so vectors never collapse to zero width.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting one past the last winner.
// Produces a one-hot grant plus its index; grant_any flags that some channel won.
module wb_rr_arbiter
   import wb_multi_initiator_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_any
);

   logic [IW-1:0] cand [N];
   logic [N-1:0]  rot_req;

   // cand[gi] is the channel examined at search position gi, i.e. (last + 1 + gi) mod N.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cand
         logic [IW:0] sum;
         assign sum         = {1'b0, last} + (IW+1)'(gi + 1);
         assign cand[gi]    = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
         assign rot_req[gi] = req[cand[gi]];
      end
   endgenerate

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (rot_req[k] && !grant_any) begin
            grant_any      = 1'b1;
            grant_idx      = cand[k];
            grant[cand[k]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_multi_initiator.sv
// N-channel classic Wishbone initiator: round-robin arbitration, one transfer in flight,
// per-channel response pulse. Define WB_MULTI_INITIATOR_TIMEOUT_EN for the bus-hang timeout.
module wb_multi_initiator
   import wb_multi_initiator_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int N_CHANNELS     = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [N_CHANNELS-1:0]               req_valid,
   output logic [N_CHANNELS-1:0]               req_ready,
   input  logic [N_CHANNELS-1:0]               req_we,
   input  logic [N_CHANNELS*ADDR_WIDTH-1:0]    req_adr,
   input  logic [N_CHANNELS*DATA_WIDTH-1:0]    req_dat,
   input  logic [N_CHANNELS*DATA_WIDTH/8-1:0]  req_sel,
   output logic [N_CHANNELS-1:0]               rsp_valid,
   output logic [DATA_WIDTH-1:0]               rsp_dat,
   output logic                                rsp_err,
   output logic [ADDR_WIDTH-1:0]               adr,
   output logic [DATA_WIDTH-1:0]               dat_w,
   output logic [DATA_WIDTH/8-1:0]             sel,
   output logic                                we,
   output logic                                cyc,
   output logic                                stb,
   input  logic [DATA_WIDTH-1:0]               dat_r,
   input  logic                                ack,
   input  logic                                err
);

   localparam int IW = idx_width(N_CHANNELS);
   localparam int SW = DATA_WIDTH / 8;

   state_e                state_q,   state_d;
   logic [IW-1:0]         last_q,    last_d;
   logic [ADDR_WIDTH-1:0] adr_q,     adr_d;
   logic [DATA_WIDTH-1:0] dat_w_q,   dat_w_d;
   logic [SW-1:0]         sel_q,     sel_d;
   logic                  we_q,      we_d;
   logic                  cyc_q,     cyc_d;
   logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [N_CHANNELS-1:0] grant;
   logic [IW-1:0]         grant_idx;
   logic                  grant_any;
   logic                  tmo_hit;

   wb_rr_arbiter #(
      .N  (N_CHANNELS),
      .IW (IW)
   ) u_arb (
      .req       (req_valid),
      .last      (last_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

`ifdef WB_MULTI_INITIATOR_TIMEOUT_EN
   localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYCLES);

   logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

   // tmo_cnt_d is the number of BUS cycles completed once the current one ends.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_q == IDLE && grant_any) begin
         tmo_cnt_d = '0;
      end else if (state_q == BUS) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   assign tmo_hit = (state_q == BUS) && (tmo_cnt_d == TMO_LIMIT);

   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
   assign tmo_hit        = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      adr_d     = adr_q;
      dat_w_d   = dat_w_q;
      sel_d     = sel_q;
      we_d      = we_q;
      cyc_d     = cyc_q;
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;
      req_ready = '0;
      unique case (state_q)
         IDLE: begin
            req_ready = grant;
            if (grant_any) begin
               adr_d   = req_adr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
               dat_w_d = req_dat[grant_idx*DATA_WIDTH +: DATA_WIDTH];
               sel_d   = req_sel[grant_idx*SW +: SW];
               we_d    = req_we[grant_idx];
               cyc_d   = 1'b1;
               last_d  = grant_idx;
               state_d = BUS;
            end
         end
         BUS: begin
            // err beats a simultaneous ack; a timeout only fires when neither arrived.
            if (err) begin
               rsp_err_d = 1'b1;
               rsp_dat_d = '0;
               cyc_d     = 1'b0;
               state_d   = RSP;
            end else if (ack) begin
               rsp_err_d = 1'b0;
               rsp_dat_d = we_q ? '0 : dat_r;
               cyc_d     = 1'b0;
               state_d   = RSP;
            end else if (tmo_hit) begin
               rsp_err_d = 1'b1;
               rsp_dat_d = '0;
               cyc_d     = 1'b0;
               state_d   = RSP;
            end
         end
         RSP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      rsp_valid = '0;
      if (state_q == RSP) begin
         rsp_valid[last_q] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         last_q    <= IW'(N_CHANNELS - 1);
         adr_q     <= '0;
         dat_w_q   <= '0;
         sel_q     <= '0;
         we_q      <= 1'b0;
         cyc_q     <= 1'b0;
         rsp_dat_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         adr_q     <= adr_d;
         dat_w_q   <= dat_w_d;
         sel_q     <= sel_d;
         we_q      <= we_d;
         cyc_q     <= cyc_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign adr     = adr_q;
   assign dat_w   = dat_w_q;
   assign sel     = sel_q;
   assign we      = we_q;
   assign cyc     = cyc_q;
   assign stb     = cyc_q;
   assign rsp_dat = rsp_dat_q;
   assign rsp_err = rsp_err_q;

endmodule
